// File: rtl/em_pio_seq_pkg.sv
// Shared definitions for the PIO pattern sequencer: register map, CSR bit positions, FSM states.

package em_pio_seq_pkg;

    localparam int unsigned IdxW = 3;
    localparam int unsigned LenW = 4;

    localparam logic [3:0] RegCtrl      = 4'd0;
    localparam logic [3:0] RegStatus    = 4'd1;
    localparam logic [3:0] RegManual    = 4'd2;
    localparam logic [3:0] RegLength    = 4'd3;
    localparam logic [3:0] RegTableBase = 4'd8;

    localparam int unsigned CtrlGo    = 0;
    localparam int unsigned CtrlLoop  = 1;
    localparam int unsigned CtrlAbort = 2;
    localparam int unsigned CtrlIrqEn = 3;

    localparam int unsigned StatBusy   = 0;
    localparam int unsigned StatDone   = 1;
    localparam int unsigned StatIdxLsb = 4;

    typedef enum logic {
        StIdle,
        StRun
    } seq_state_e;

    function automatic logic [LenW-1:0] clamp_length(input logic [LenW-1:0] len,
                                                     input int unsigned depth);
        if (32'(len) > depth) begin
            return LenW'(depth);
        end
        return len;
    endfunction

endpackage

// File: rtl/em_pio_seq_table.sv
// Pattern table register file: one write port, one read port for the sequencer, one for the bus.

module em_pio_seq_table #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ENTRY_W = 26,
    parameter int unsigned IDX_W   = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]   seq_addr_i,
    output logic [ENTRY_W-1:0] seq_data_o,
    input  logic [IDX_W-1:0]   bus_addr_i,
    output logic [ENTRY_W-1:0] bus_data_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (32'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Indices beyond DEPTH read as zero.
    assign seq_data_o = (32'(seq_addr_i) < DEPTH) ? mem_q[seq_addr_i] : '0;
    assign bus_data_o = (32'(bus_addr_i) < DEPTH) ? mem_q[bus_addr_i] : '0;

endmodule

// File: rtl/em_pio_pattern_sequencer.sv
// Avalon-MM PIO output that can autonomously step through a table of {value, dwell} entries.

module em_pio_pattern_sequencer
    import em_pio_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DWELL_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              irq
);

    localparam int unsigned EntryW = DATA_W + DWELL_W;

    seq_state_e          state_q;
    logic [IdxW-1:0]     idx_q;
    logic [DWELL_W-1:0]  cnt_q;
    logic [DATA_W-1:0]   out_q;
    logic                done_q;
    logic                irq_q;
    logic                loop_q;
    logic                irq_en_q;
    logic [DATA_W-1:0]   manual_q;
    logic [LenW-1:0]     length_q;

    logic                wr;
    logic                wr_ctrl;
    logic                wr_status;
    logic                wr_manual;
    logic                wr_length;
    logic                wr_table;
    logic                go;
    logic                abort;
    logic                done_clr;
    logic                done_set;
    logic                last;
    logic                loop_ok;
    logic [DATA_W-1:0]   manual_nxt;
    logic [IdxW-1:0]     seq_addr;
    logic [EntryW-1:0]   seq_entry;
    logic [EntryW-1:0]   bus_entry;
    logic [DATA_W-1:0]   seq_value;
    logic [DWELL_W-1:0]  seq_dwell;
    logic [DWELL_W-1:0]  seq_cnt;
    logic [EntryW-1:0]   table_wdata;
    logic                unused_wdata;

    assign wr        = chipselect & ~write_n;
    assign wr_ctrl   = wr && (address == RegCtrl);
    assign wr_status = wr && (address == RegStatus);
    assign wr_manual = wr && (address == RegManual);
    assign wr_length = wr && (address == RegLength);
    assign wr_table  = wr && address[3];

    assign go       = wr_ctrl & writedata[CtrlGo];
    assign abort    = wr_ctrl & writedata[CtrlAbort];
    assign done_clr = wr_status & writedata[StatDone];

    assign table_wdata  = {writedata[16 +: DWELL_W], writedata[DATA_W-1:0]};
    assign unused_wdata = ^writedata;

    // A MANUAL write is visible on out_port on the same edge that stores it.
    assign manual_nxt = wr_manual ? writedata[DATA_W-1:0] : manual_q;

    // LENGTH is compared live, so a shortened pass ends at the current entry.
    assign last     = ({1'b0, idx_q} + 4'd1) >= length_q;
    assign loop_ok  = loop_q && (length_q != '0);
    assign seq_addr = ((state_q == StRun) && !last) ? idx_q + 3'd1 : '0;

    assign seq_value = seq_entry[DATA_W-1:0];
    assign seq_dwell = seq_entry[DATA_W +: DWELL_W];
    assign seq_cnt   = (seq_dwell == '0) ? '0 : seq_dwell - DWELL_W'(1);

    assign done_set = (state_q == StRun) && !abort && (cnt_q == '0) && last && !loop_ok;

    em_pio_seq_table #(
        .DEPTH   (DEPTH),
        .ENTRY_W (EntryW),
        .IDX_W   (IdxW)
    ) u_table (
        .clk        (clk),
        .reset_n    (reset_n),
        .we_i       (wr_table),
        .waddr_i    (address[IdxW-1:0]),
        .wdata_i    (table_wdata),
        .seq_addr_i (seq_addr),
        .seq_data_o (seq_entry),
        .bus_addr_i (address[IdxW-1:0]),
        .bus_data_o (bus_entry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loop_q   <= 1'b0;
            irq_en_q <= 1'b0;
            manual_q <= '0;
            length_q <= '0;
        end else begin
            if (wr_ctrl) begin
                loop_q   <= writedata[CtrlLoop];
                irq_en_q <= writedata[CtrlIrqEn];
            end
            if (wr_manual) begin
                manual_q <= writedata[DATA_W-1:0];
            end
            if (wr_length) begin
                length_q <= clamp_length(writedata[LenW-1:0], DEPTH);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irq_q <= done_q & irq_en_q;
            // Set has priority over a simultaneous software clear.
            if (done_set) begin
                done_q <= 1'b1;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    out_q <= manual_nxt;
                    if (go && !abort && (length_q != '0)) begin
                        state_q <= StRun;
                        idx_q   <= '0;
                        out_q   <= seq_value;
                        cnt_q   <= seq_cnt;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                        out_q   <= manual_nxt;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end else if (!last) begin
                        idx_q <= idx_q + 3'd1;
                        out_q <= seq_value;
                        cnt_q <= seq_cnt;
                    end else if (loop_ok) begin
                        idx_q <= '0;
                        out_q <= seq_value;
                        cnt_q <= seq_cnt;
                    end else begin
                        state_q <= StIdle;
                        out_q   <= manual_nxt;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            RegCtrl: begin
                readdata[CtrlLoop]  = loop_q;
                readdata[CtrlIrqEn] = irq_en_q;
            end
            RegStatus: begin
                readdata[StatBusy]             = (state_q == StRun);
                readdata[StatDone]             = done_q;
                readdata[StatIdxLsb +: IdxW]   = idx_q;
            end
            RegManual: readdata[DATA_W-1:0] = manual_q;
            RegLength: readdata[LenW-1:0]   = length_q;
            default: begin
                if (address[3]) begin
                    readdata[DATA_W-1:0]  = bus_entry[DATA_W-1:0];
                    readdata[16 +: DWELL_W] = bus_entry[DATA_W +: DWELL_W];
                end
            end
        endcase
    end

    assign out_port = out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_em_pio_pattern_sequencer.sv
// Directed bench for the PIO pattern sequencer; per-cycle out_port expectations are queued.

module tb_em_pio_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;
    logic        irq;

    logic [9:0]  exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    em_pio_pattern_sequencer #(
        .DATA_W  (10),
        .DEPTH   (8),
        .DWELL_W (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score out_port against the queue head.
    task automatic tick();
        logic [9:0] e;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_port", {22'b0, out_port}, {22'b0, e});
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_pattern(input int passes);
        for (int p = 0; p < passes; p++) begin
            exp_q.push_back(10'h001);
            exp_q.push_back(10'h001);
            exp_q.push_back(10'h001);
            exp_q.push_back(10'h002);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] mask,
                             input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(tag, readdata & mask, exp);
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("reset_out_port", {22'b0, out_port}, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check_reg("reset_status", 4'd1, 32'hFFFF_FFFF, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        exp_q.push_back(10'h155);
        bus_write(4'd2, 32'h155);

        // Single pass: 0x001 for 3 cycles, 0x002 for 1 (dwell 0 acts as 1), then MANUAL
        bus_write(4'd8, 32'h0003_0001);
        bus_write(4'd9, 32'h0000_0002);
        bus_write(4'd3, 32'd2);
        push_pattern(1);
        exp_q.push_back(10'h155);
        exp_q.push_back(10'h155);
        bus_write(4'd0, 32'h1);
        ticks(5);
        check_reg("pass_done", 4'd1, 32'h3, 32'h2);
        check("pass_irq_masked", {31'b0, irq}, 32'h0);

        // Looping with IRQ enabled, stop after LOOP is cleared
        bus_write(4'd1, 32'h2);
        check_reg("done_cleared", 4'd1, 32'h3, 32'h0);
        bus_write(4'd0, 32'hA);
        check_reg("ctrl_readback", 4'd0, 32'hFFFF_FFFF, 32'hA);
        push_pattern(4);
        exp_q.push_back(10'h155);
        bus_write(4'd0, 32'hB);
        ticks(11);
        check_reg("loop_busy", 4'd1, 32'h3, 32'h1);
        bus_write(4'd0, 32'h8);
        ticks(4);
        check_reg("loop_end_done", 4'd1, 32'h3, 32'h2);
        check("irq_lag", {31'b0, irq}, 32'h0);
        tick();
        check("irq_set", {31'b0, irq}, 32'h1);
        bus_write(4'd1, 32'h2);
        check_reg("status_clr", 4'd1, 32'h3, 32'h0);
        tick();
        check("irq_clr", {31'b0, irq}, 32'h0);

        // ABORT mid-entry
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h155);
        bus_write(4'd0, 32'h1);
        tick();
        bus_write(4'd0, 32'h4);
        check_reg("abort_status", 4'd1, 32'h3, 32'h0);

        // GO+ABORT together while running
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h155);
        bus_write(4'd0, 32'h1);
        tick();
        bus_write(4'd0, 32'h5);
        check_reg("goabort_status", 4'd1, 32'h3, 32'h0);

        // GO with LENGTH=0 is ignored
        bus_write(4'd3, 32'd0);
        exp_q.push_back(10'h155);
        exp_q.push_back(10'h155);
        bus_write(4'd0, 32'h1);
        tick();
        check_reg("len0_idle", 4'd1, 32'h3, 32'h0);

        // LENGTH clamp and live table rewrite
        bus_write(4'd3, 32'd15);
        check_reg("length_clamp", 4'd3, 32'hFFFF_FFFF, 32'd8);
        bus_write(4'd3, 32'd2);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h3AA);
        exp_q.push_back(10'h155);
        bus_write(4'd0, 32'h1);
        bus_write(4'd9, 32'h0000_03AA);
        ticks(3);
        check_reg("table1_read", 4'd9, 32'hFFFF_FFFF, 32'h0000_03AA);
        check_reg("table0_read", 4'd8, 32'hFFFF_FFFF, 32'h0003_0001);
        check_reg("unmapped_read", 4'd5, 32'hFFFF_FFFF, 32'h0);

        // Asynchronous reset mid-run
        exp_q.push_back(10'h001);
        bus_write(4'd0, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out", {22'b0, out_port}, 32'h0);
        check_reg("async_reset_status", 4'd1, 32'hFFFF_FFFF, 32'h0);
        check_reg("async_reset_table", 4'd8, 32'hFFFF_FFFF, 32'h0);
        check_reg("async_reset_length", 4'd3, 32'hFFFF_FFFF, 32'h0);
        exp_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
